// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock generator: per-channel period, high time and
// start phase, with shadowed reconfiguration that takes effect at the channel's wrap edge.
module clk_div_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] ch_wrap
);
  localparam int PAD_N = 1 << CH_W;
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] pending_s;
  logic [PAD_N-1:0]  pending_pad_s;
  logic              ch_valid_s;
  logic              cfg_bad_s;
  logic              accept_s;
  logic              cfg_err_r;

  // Zero-extend pending flags so an out-of-range channel index never selects past the vector.
  always_comb begin
    pending_pad_s               = {PAD_N{1'b0}};
    pending_pad_s[NUM_CH-1:0]   = pending_s;
  end

  assign ch_valid_s = ({1'b0, cfg_ch} < NUM_CH_V);
  assign cfg_ready  = ch_valid_s ? !pending_pad_s[cfg_ch] : 1'b1;
  assign accept_s   = cfg_valid && cfg_ready;
  assign cfg_bad_s  = (cfg_div < DIV_W'(2)) || (cfg_high == {DIV_W{1'b0}}) ||
                      (cfg_high >= cfg_div) || (cfg_phase >= cfg_div) || !ch_valid_s;
  assign cfg_err    = cfg_err_r;

  // Rejected-write pulse, one cycle after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= accept_s && cfg_bad_s;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_r, high_r, phase_r;
    logic [DIV_W-1:0] sh_div_r, sh_high_r, sh_phase_r;
    logic [DIV_W-1:0] cnt_r;
    logic             pend_r, act_r, clk_r, wrap_r;
    logic             hit_s, at_end_s;
    logic [DIV_W-1:0] st_phase_s, st_high_s;

    // A write landing on an idle channel on its start edge is used immediately.
    always_comb begin
      hit_s    = accept_s && !cfg_bad_s && (cfg_ch == CH_W'(i));
      at_end_s = (cnt_r == (div_r - DIV_W'(1)));
      if (hit_s) begin
        st_phase_s = cfg_phase;
        st_high_s  = cfg_high;
      end else begin
        st_phase_s = phase_r;
        st_high_s  = high_r;
      end
    end

    // Per-channel counter, config registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        div_r      <= DIV_W'(2);
        high_r     <= DIV_W'(1);
        phase_r    <= {DIV_W{1'b0}};
        sh_div_r   <= {DIV_W{1'b0}};
        sh_high_r  <= {DIV_W{1'b0}};
        sh_phase_r <= {DIV_W{1'b0}};
        cnt_r      <= {DIV_W{1'b0}};
        pend_r     <= 1'b0;
        act_r      <= 1'b0;
        clk_r      <= 1'b0;
        wrap_r     <= 1'b0;
      end else begin
        wrap_r <= 1'b0;
        if (!act_r) begin
          if (hit_s) begin
            div_r   <= cfg_div;
            high_r  <= cfg_high;
            phase_r <= cfg_phase;
          end
          if (ch_enable[i]) begin
            act_r <= 1'b1;
            cnt_r <= st_phase_s;
            clk_r <= (st_phase_s < st_high_s);
          end else begin
            cnt_r <= {DIV_W{1'b0}};
            clk_r <= 1'b0;
          end
        end else begin
          if (hit_s) begin
            sh_div_r   <= cfg_div;
            sh_high_r  <= cfg_high;
            sh_phase_r <= cfg_phase;
            pend_r     <= 1'b1;
          end
          if (at_end_s) begin
            wrap_r <= 1'b1;
            cnt_r  <= {DIV_W{1'b0}};
            if (pend_r) begin
              div_r   <= sh_div_r;
              high_r  <= sh_high_r;
              phase_r <= sh_phase_r;
              pend_r  <= 1'b0;
            end
            // Count 0 is always inside the high phase since high >= 1.
            if (ch_enable[i]) begin
              clk_r <= 1'b1;
            end else begin
              act_r <= 1'b0;
              clk_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
            clk_r <= ((cnt_r + DIV_W'(1)) < high_r);
          end
        end
      end
    end

    assign pending_s[i] = pend_r;
    assign clk_out[i]   = clk_r;
    assign ch_active[i] = act_r;
    assign ch_wrap[i]   = wrap_r;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: default waveform, phase start, shadowed reconfig,
// rejected writes, graceful stop/restart and asynchronous reset.
module tb_clk_div_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div, cfg_high, cfg_phase;
  logic [3:0] ch_enable;
  logic       cfg_ready, cfg_err;
  logic [3:0] clk_out, ch_active, ch_wrap;

  logic       cfg_valid3;
  logic [1:0] cfg_ch3;
  logic [2:0] ch_enable3;
  logic       cfg_ready3, cfg_err3;
  logic [2:0] clk_out3, ch_active3, ch_wrap3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_gen #(.NUM_CH(4), .DIV_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .ch_enable(ch_enable), .clk_out(clk_out), .ch_active(ch_active), .ch_wrap(ch_wrap)
  );

  // Three-channel instance so that cfg_ch == NUM_CH is representable.
  clk_div_gen #(.NUM_CH(3), .DIV_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase), .cfg_err(cfg_err3),
    .ch_enable(ch_enable3), .clk_out(clk_out3), .ch_active(ch_active3), .ch_wrap(ch_wrap3)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; cfg_valid = 1'b0; cfg_valid3 = 1'b0; ch_enable = 4'b0000; ch_enable3 = 3'b000;
    cfg_ch = 2'd0; cfg_ch3 = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] h, input logic [7:0] p);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = d; cfg_high = h; cfg_phase = p;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({clk_out, ch_active, ch_wrap, cfg_err, cfg_ready} !== {12'h000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", {clk_out, ch_active, ch_wrap, cfg_err, cfg_ready}, {12'h000, 1'b0, 1'b1});
    end
    checks++;
    if ({clk_out3, ch_active3, ch_wrap3, cfg_err3} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs3 got %b exp 0", {clk_out3, ch_active3, ch_wrap3, cfg_err3});
    end
  endtask

  task automatic test_default;
    logic e_clk [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic e_wrp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    ch_enable = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({clk_out[0], ch_wrap[0], ch_active[0]} !== {e_clk[i], e_wrp[i], 1'b1}) begin
        errors++;
        $display("FAIL default_wave cycle %0d got clk/wrap/act %b exp %b", i,
                 {clk_out[0], ch_wrap[0], ch_active[0]}, {e_clk[i], e_wrp[i], 1'b1});
      end
    end
  endtask

  task automatic test_phase;
    logic e_clk [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic e_wrp [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    write_cfg(2'd1, 8'd5, 8'd2, 8'd3);
    checks++;
    if ({cfg_err, ch_active[1]} !== 2'b00) begin
      errors++;
      $display("FAIL phase_idle_write got err/act %b exp 00", {cfg_err, ch_active[1]});
    end
    ch_enable = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({clk_out[1], ch_wrap[1]} !== {e_clk[i], e_wrp[i]}) begin
        errors++;
        $display("FAIL phase_wave cycle %0d got clk/wrap %b exp %b", i, {clk_out[1], ch_wrap[1]}, {e_clk[i], e_wrp[i]});
      end
    end
  endtask

  task automatic test_reconfig;
    logic e_clk [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic e_rdy [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic e_wrp [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    write_cfg(2'd0, 8'd4, 8'd2, 8'd0);
    ch_enable = 4'b0001;
    tick();
    tick();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; cfg_high = 8'd3; cfg_phase = 8'd0;
    checks++;
    if ({cfg_ready, clk_out[0]} !== 2'b11) begin
      errors++;
      $display("FAIL reconfig_pre got ready/clk %b exp 11", {cfg_ready, clk_out[0]});
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      cfg_valid = 1'b0;
      checks++;
      if ({clk_out[0], cfg_ready, ch_wrap[0]} !== {e_clk[i], e_rdy[i], e_wrp[i]}) begin
        errors++;
        $display("FAIL reconfig_wave cycle %0d got clk/ready/wrap %b exp %b", i,
                 {clk_out[0], cfg_ready, ch_wrap[0]}, {e_clk[i], e_rdy[i], e_wrp[i]});
      end
    end
  endtask

  task automatic test_reject;
    logic [7:0] v_div [4] = '{8'd1, 8'd4, 8'd4, 8'd4};
    logic [7:0] v_hi  [4] = '{8'd1, 8'd0, 8'd4, 8'd2};
    logic [7:0] v_ph  [4] = '{8'd0, 8'd0, 8'd0, 8'd4};
    logic       e_clk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      write_cfg(2'd0, v_div[i], v_hi[i], v_ph[i]);
      checks++;
      if (cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL reject_pulse vec %0d got %b exp 1", i, cfg_err);
      end
      tick();
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL reject_clear vec %0d got %b exp 0", i, cfg_err);
      end
    end
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 8'd4; cfg_high = 8'd2; cfg_phase = 8'd0;
    checks++;
    if (cfg_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reject_badch_ready got %b exp 1", cfg_ready3);
    end
    tick();
    cfg_valid3 = 1'b0;
    checks++;
    if ({cfg_err3, ch_active3} !== 4'b1000) begin
      errors++;
      $display("FAIL reject_badch got err/act %b exp 1000", {cfg_err3, ch_active3});
    end
    tick();
    checks++;
    if (cfg_err3 !== 1'b0) begin
      errors++;
      $display("FAIL reject_badch_clear got %b exp 0", cfg_err3);
    end
    ch_enable = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (clk_out[0] !== e_clk[i]) begin
        errors++;
        $display("FAIL reject_cfg_kept cycle %0d got %b exp %b", i, clk_out[0], e_clk[i]);
      end
    end
  endtask

  task automatic test_stop;
    logic e_clk [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e_act [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic e_wrp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic r_clk [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic r_wrp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    write_cfg(2'd2, 8'd8, 8'd4, 8'd0);
    ch_enable = 4'b0100;
    tick();
    tick();
    ch_enable = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({clk_out[2], ch_active[2], ch_wrap[2]} !== {e_clk[i], e_act[i], e_wrp[i]}) begin
        errors++;
        $display("FAIL stop_wave cycle %0d got clk/act/wrap %b exp %b", i,
                 {clk_out[2], ch_active[2], ch_wrap[2]}, {e_clk[i], e_act[i], e_wrp[i]});
      end
    end
    ch_enable = 4'b0100;
    tick();
    ch_enable = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({clk_out[2], ch_active[2], ch_wrap[2]} !== {r_clk[i], 1'b1, r_wrp[i]}) begin
        errors++;
        $display("FAIL stop_cancel cycle %0d got clk/act/wrap %b exp %b", i,
                 {clk_out[2], ch_active[2], ch_wrap[2]}, {r_clk[i], 1'b1, r_wrp[i]});
      end
      if (i == 1) ch_enable = 4'b0100;
    end
  endtask

  task automatic test_cfg_stop;
    logic e_clk [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    ch_enable = 4'b0010;
    tick();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4; cfg_high = 8'd2; cfg_phase = 8'd0;
    ch_enable = 4'b0000;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, ch_active[1]} !== 2'b01) begin
      errors++;
      $display("FAIL cfgstop_pending got ready/act %b exp 01", {cfg_ready, ch_active[1]});
    end
    tick();
    checks++;
    if ({ch_active[1], ch_wrap[1], clk_out[1], cfg_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL cfgstop_edge got act/wrap/clk/ready %b exp 0101", {ch_active[1], ch_wrap[1], clk_out[1], cfg_ready});
    end
    ch_enable = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (clk_out[1] !== e_clk[i]) begin
        errors++;
        $display("FAIL cfgstop_newcfg cycle %0d got %b exp %b", i, clk_out[1], e_clk[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] e_clk [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic [3:0] e_wrp [4] = '{4'h0, 4'h0, 4'hF, 4'h0};
    do_reset();
    for (int c = 0; c < 4; c++) write_cfg(2'(c), 8'd4, 8'd2, 8'd0);
    ch_enable = 4'hF;
    tick();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; cfg_high = 8'd3; cfg_phase = 8'd0;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if ({clk_out, ch_active, cfg_ready} !== {4'hF, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL arst_pre got clk/act/ready %b exp %b", {clk_out, ch_active, cfg_ready}, {4'hF, 4'hF, 1'b0});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({clk_out, ch_active, ch_wrap, cfg_err} !== 13'b0) begin
      errors++;
      $display("FAIL arst_immediate got %b exp 0", {clk_out, ch_active, ch_wrap, cfg_err});
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_ready got %b exp 1", cfg_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({clk_out, ch_wrap, ch_active} !== {e_clk[i], e_wrp[i], 4'hF}) begin
        errors++;
        $display("FAIL arst_restart cycle %0d got clk/wrap/act %b exp %b", i,
                 {clk_out, ch_wrap, ch_active}, {e_clk[i], e_wrp[i], 4'hF});
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_high = 8'd0; cfg_phase = 8'd0;
    ch_enable = 4'b0000; cfg_valid3 = 1'b0; cfg_ch3 = 2'd0; ch_enable3 = 3'b000;
    test_reset();
    test_default();
    test_phase();
    test_reconfig();
    test_reject();
    test_stop();
    test_cfg_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent generated-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, meaning width of the divide, high-time and phase fields.
REQ-003 SHALL have port clk  input  1  reference clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration write request.
REQ-006 SHALL have port cfg_ready  output  1  write accepted when cfg_valid and cfg_ready are both high.
REQ-007 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-008 SHALL have port cfg_div  input  DIV_W  period in reference cycles.
REQ-009 SHALL have port cfg_high  input  DIV_W  high time in reference cycles.
REQ-010 SHALL have port cfg_phase  input  DIV_W  start count applied on enable.
REQ-011 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected write.
REQ-012 SHALL have port ch_enable  input  NUM_CH  per-channel run request, level-sensitive.
REQ-013 SHALL have port clk_out  output  NUM_CH  generated clocks, registered.
REQ-014 SHALL have port ch_active  output  NUM_CH  channel currently toggling.
REQ-015 SHALL have port ch_wrap  output  NUM_CH  one-cycle pulse when a channel count wraps to 0.

Function
REQ-016 SHALL keep per channel: active config (div, high, phase), shadow config, pending flag, count (DIV_W), active flag.
REQ-017 SHALL drive cfg_ready = !pending[cfg_ch]; cfg_ch >= NUM_CH SHALL be treated as invalid.
REQ-018 SHALL reject an accepted write if cfg_div < 2, cfg_high == 0, cfg_high >= cfg_div, cfg_phase >= cfg_div, or cfg_ch >= NUM_CH: cfg_err high the next cycle, no state change.
REQ-019 SHALL, for a valid write to an inactive channel, load the active config at the accepting edge; pending stays 0.
REQ-020 SHALL, for a valid write to an active channel, load the shadow config and set pending; the shadow is copied to the active config, and pending cleared, at the channel's next wrap edge.
REQ-021 SHALL start an inactive channel at the edge where ch_enable is sampled high: active=1, count=phase, clk_out=(phase<high), using the config in effect after that edge (a same-edge write to the idle channel applies).
REQ-022 SHALL, while active, increment count each edge; at count==div-1 wrap to 0 and pulse ch_wrap for one cycle.
REQ-023 SHALL drive clk_out registered as active && (count<high); no combinational path to clk_out.
REQ-024 SHALL, when ch_enable is low while active, run until the next wrap edge; at that edge set active=0, count=0, clk_out=0, and still pulse ch_wrap. No truncated high phase.
REQ-025 SHALL cancel a pending stop if ch_enable is high again when sampled at the wrap edge; the channel continues without a gap.
REQ-026 SHALL keep channels fully independent; simultaneous wraps, starts and stops on different channels all take effect on the same edge.
REQ-027 SHALL, at a wrap edge where a pending config and a stop coincide, apply the config and then stop.

Reset
REQ-028 SHALL, while rst is high, force clk_out=0, ch_active=0, ch_wrap=0, cfg_err=0, count=0, pending=0, and active config div=2, high=1, phase=0 on all channels, asynchronously.
REQ-029 SHALL, on rst assertion mid-period or mid-update, discard the shadow config; after release, a channel with ch_enable high starts at the first rising edge.

Verification
REQ-030 SHALL cover: reset release, ch_enable[0]=1, default config -> clk_out[0] = 1,0,1,0 on successive edges; ch_wrap[0] pulses every 2 cycles.
REQ-031 SHALL cover: ch1 written div=5 high=2 phase=3, then enabled -> clk_out[1] = 0,0,1,1,0,0,0,1,1... (count 3,4,0,1,2,...).
REQ-032 SHALL cover: ch0 running div=4 high=2, write div=6 high=3 mid-period -> cfg_ready low until the wrap, old waveform finishes the period, new 3-high/3-low starts at count 0.
REQ-033 SHALL cover: writes with div=1, high=0, high=div, phase=div and cfg_ch=NUM_CH -> cfg_err pulses once each, active config unchanged.
REQ-034 SHALL cover: ch_enable dropped while clk_out high (div=8 high=4) -> output completes the high phase and low phase, ch_active falls at the wrap; re-enabling before the wrap gives no gap.
REQ-035 SHALL cover: rst asserted asynchronously mid-high with all 4 channels active and one pending write -> all outputs 0 immediately, cfg_ready=1 after release.
